dm_responder: RTL and testbench

Data-memory responder for the pipelined RV32 core: the slave end of the core's MEM-stage data port (address, write data, write strobe, DMType). It performs byte/half/word stores with lane merging on the clock edge and returns sign- or zero-extended load data combinationally, so the core's MEM/WB register captures it at the end of the MEM cycle. It also detects misaligned stores, latches a sticky fault record, and exposes a debug read port.

---
 rtl/dm_pkg.sv | 23 ++
 rtl/dm_lane_mux.sv | 66 ++++++
 rtl/dm_responder.sv | 109 ++++++++++
 tb/tb_dm_responder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: access-type codes and MMIO map.
// The MMIO map is only decoded when DM_MMIO_EN is defined.
package dm_pkg;

  typedef logic [2:0] dm_type_t;

  localparam dm_type_t DM_WORD   = 3'b000;
  localparam dm_type_t DM_HALF_S = 3'b001;
  localparam dm_type_t DM_HALF_U = 3'b010;
  localparam dm_type_t DM_BYTE_S = 3'b011;
  localparam dm_type_t DM_BYTE_U = 3'b100;

  localparam logic [15:0] MMIO_BASE_HI = 16'hFFFF;
  localparam logic [15:0] MMIO_CNT_LO  = 16'h0000;
  localparam logic [15:0] MMIO_CNT_HI  = 16'h0004;
  localparam logic [15:0] MMIO_GPIO    = 16'h0008;

  // Codes 101..111 are treated as full-word accesses.
  function automatic logic is_word_type(input dm_type_t t);
    return !(t == DM_HALF_S || t == DM_HALF_U || t == DM_BYTE_S || t == DM_BYTE_U);
  endfunction

endpackage

// File: rtl/dm_lane_mux.sv
// Byte-lane steering for the data port: store byte enables and merge, load
// extraction with sign/zero extension, and misaligned-store detection.
module dm_lane_mux
  import dm_pkg::*;
(
  input  logic [1:0]  addr,
  input  dm_type_t    dm_type,
  input  logic [31:0] ram_word,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] st_word,
  output logic [31:0] ld_word,
  output logic        misaligned
);

  function automatic logic [31:0] sext16(input logic signed [15:0] v);
    logic signed [31:0] w;
    w = 32'(v);
    return w;
  endfunction

  function automatic logic [31:0] sext8(input logic signed [7:0] v);
    logic signed [31:0] w;
    w = 32'(v);
    return w;
  endfunction

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] st_lanes;

  assign half_sel = addr[1] ? ram_word[31:16] : ram_word[15:0];
  assign byte_sel = ram_word[8*addr +: 8];

  always_comb begin
    be         = 4'b1111;
    st_lanes   = wdata;
    ld_word    = ram_word;
    misaligned = 1'b0;
    case (dm_type)
      DM_HALF_S, DM_HALF_U: begin
        be         = addr[1] ? 4'b1100 : 4'b0011;
        st_lanes   = {wdata[15:0], wdata[15:0]};
        ld_word    = (dm_type == DM_HALF_S) ? sext16(half_sel) : {16'h0, half_sel};
        misaligned = addr[0];
      end
      DM_BYTE_S, DM_BYTE_U: begin
        be         = 4'b0001 << addr;
        st_lanes   = {4{wdata[7:0]}};
        ld_word    = (dm_type == DM_BYTE_S) ? sext8(byte_sel) : {24'h0, byte_sel};
      end
      default: begin
        misaligned = (addr != 2'b00);
      end
    endcase
  end

  // Unselected lanes keep the current RAM contents.
  always_comb begin
    st_word = ram_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) st_word[8*i +: 8] = st_lanes[8*i +: 8];
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory slave for the RV32 MEM stage: lane-merged stores, combinational
// extended loads, sticky misaligned-store record, debug port. Optional MMIO via DM_MMIO_EN.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_w,
  input  logic [31:0]   Addr_in,
  input  logic [31:0]   wdata,
  input  logic [2:0]    DMType,
  output logic [31:0]   Data_out,
  output logic          fault,
  output logic [31:0]   fault_addr,
  output logic [31:0]   gpio_out,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data
);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [31:0]   ram_word;
  logic [3:0]    be;
  logic [31:0]   st_word;
  logic [31:0]   ld_word;
  logic          misaligned;
  logic          is_mmio;
  logic          store_ok;
  logic          ram_we;

  assign word_idx = Addr_in[AW+1:2];
  assign ram_word = mem[word_idx];
  assign dbg_data = mem[dbg_addr];

  dm_lane_mux u_lane_mux (
    .addr       (Addr_in[1:0]),
    .dm_type    (DMType),
    .ram_word   (ram_word),
    .wdata      (wdata),
    .be         (be),
    .st_word    (st_word),
    .ld_word    (ld_word),
    .misaligned (misaligned)
  );

  assign store_ok = mem_w && !misaligned;
  assign ram_we   = store_ok && !is_mmio;

  // RAM has no reset, so a store coinciding with reset still commits.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= st_word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault      <= 1'b0;
      fault_addr <= 32'h0;
    end else if (mem_w && misaligned && !fault) begin
      fault      <= 1'b1;
      fault_addr <= Addr_in;
    end
  end

`ifdef DM_MMIO_EN
  logic [63:0] cycle_cnt;
  logic [31:0] gpio_q;
  logic [31:0] mmio_rdata;
  logic        gpio_we;

  assign is_mmio = (Addr_in[31:16] == MMIO_BASE_HI);
  assign gpio_we = store_ok && is_mmio && (Addr_in[15:0] == MMIO_GPIO) && is_word_type(DMType);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= 64'h0;
      gpio_q    <= 32'h0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (gpio_we) gpio_q <= wdata;
    end
  end

  // MMIO reads are always full words regardless of DMType.
  always_comb begin
    mmio_rdata = 32'h0;
    case ({Addr_in[15:2], 2'b00})
      MMIO_CNT_LO: mmio_rdata = cycle_cnt[31:0];
      MMIO_CNT_HI: mmio_rdata = cycle_cnt[63:32];
      MMIO_GPIO:   mmio_rdata = gpio_q;
      default:     mmio_rdata = 32'h0;
    endcase
  end

  assign gpio_out = gpio_q;
  assign Data_out = is_mmio ? mmio_rdata : ld_word;
`else
  assign is_mmio  = 1'b0;
  assign gpio_out = 32'h0;
  assign Data_out = ld_word;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: loads/extension, lane merge, faults,
// read-during-write, aliasing and the MMIO / non-MMIO address window.
module tb_dm_responder;
  import dm_pkg::*;

  localparam int DEPTH_WORDS = 1024;
  localparam int AW = $clog2(DEPTH_WORDS);

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_w;
  logic [31:0]   Addr_in;
  logic [31:0]   wdata;
  logic [2:0]    DMType;
  logic [31:0]   Data_out;
  logic          fault;
  logic [31:0]   fault_addr;
  logic [31:0]   gpio_out;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_data;

  int n_checks = 0;
  int n_errors = 0;

  dm_responder #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_w      (mem_w),
    .Addr_in    (Addr_in),
    .wdata      (wdata),
    .DMType     (DMType),
    .Data_out   (Data_out),
    .fault      (fault),
    .fault_addr (fault_addr),
    .gpio_out   (gpio_out),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    @(negedge clk);
    mem_w = 1'b1; Addr_in = a; wdata = d; DMType = t;
    @(negedge clk);
    mem_w = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [31:0] a, input logic [2:0] t,
                            input logic [31:0] exp);
    mem_w = 1'b0; Addr_in = a; DMType = t;
    #1;
    check(tag, Data_out, exp);
  endtask

  initial begin
    reset = 1'b1; mem_w = 1'b0; Addr_in = '0; wdata = '0; DMType = DM_WORD; dbg_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_fault", {31'h0, fault}, 32'h0);
    check("rst_fault_addr", fault_addr, 32'h0);
    check("rst_gpio", gpio_out, 32'h0);

`ifdef DM_MMIO_EN
    // Reset released at a negedge; ten posedges later the counter reads 10.
    repeat (10) @(posedge clk);
    #1;
    load_check("cnt_lo", 32'hFFFF_0000, DM_WORD, 32'd10);
    load_check("cnt_hi", 32'hFFFF_0004, DM_BYTE_S, 32'd0);
`endif

    store(32'h10, 32'h8000_00FF, DM_WORD);
    load_check("lw_10",  32'h10, DM_WORD,   32'h8000_00FF);
    load_check("lh_10",  32'h10, DM_HALF_S, 32'h0000_00FF);
    load_check("lhu_10", 32'h10, DM_HALF_U, 32'h0000_00FF);
    load_check("lb_10",  32'h10, DM_BYTE_S, 32'hFFFF_FFFF);
    load_check("lbu_10", 32'h10, DM_BYTE_U, 32'h0000_00FF);
    load_check("lh_12",  32'h12, DM_HALF_S, 32'hFFFF_8000);
    load_check("lhu_12", 32'h12, DM_HALF_U, 32'h0000_8000);
    load_check("lb_13",  32'h13, DM_BYTE_S, 32'hFFFF_FF80);
    load_check("lw_13",  32'h13, 3'b111,    32'h8000_00FF);

    store(32'h20, 32'h0, DM_WORD);
    store(32'h22, 32'hFFFF_FFAB, DM_BYTE_U);
    store(32'h20, 32'hCAFE_1234, DM_HALF_S);
    load_check("merge_20", 32'h20, DM_WORD, 32'h00AB_1234);
    dbg_addr = AW'(8);
    #1;
    check("dbg_20", dbg_data, 32'h00AB_1234);
    store(32'h24, 32'h0, DM_WORD);
    store(32'h24, 32'h11, DM_BYTE_S);
    store(32'h25, 32'h22, DM_BYTE_U);
    load_check("bb_merge", 32'h24, DM_WORD, 32'h0000_2211);

    store(32'h30, 32'h0, DM_WORD);
    store(32'h21, 32'hDEAD_BEEF, DM_WORD);
    load_check("misal_sw_ram", 32'h20, DM_WORD, 32'h00AB_1234);
    check("fault_set", {31'h0, fault}, 32'h1);
    check("fault_addr_1", fault_addr, 32'h21);
    store(32'h33, 32'hFFFF_9999, DM_HALF_U);
    check("fault_addr_held", fault_addr, 32'h21);
    load_check("misal_sh_ram", 32'h30, DM_WORD, 32'h0);

    // Store during reset: registers clear, RAM write still lands.
    @(negedge clk);
    reset = 1'b1; mem_w = 1'b1; Addr_in = 32'h50; wdata = 32'h1357_9BDF; DMType = DM_WORD;
    @(negedge clk);
    reset = 1'b0; mem_w = 1'b0;
    #1;
    check("rst_clr_fault", {31'h0, fault}, 32'h0);
    check("rst_clr_addr", fault_addr, 32'h0);
    load_check("rst_store", 32'h50, DM_WORD, 32'h1357_9BDF);

    store(32'h40, 32'h77, DM_WORD);
    @(negedge clk);
    mem_w = 1'b1; Addr_in = 32'h40; wdata = 32'h1; DMType = DM_WORD;
    #1;
    check("rdw_old", Data_out, 32'h77);
    @(negedge clk);
    mem_w = 1'b0;
    load_check("rdw_new", 32'h40, DM_WORD, 32'h1);

    store(32'h1000, 32'h55, DM_WORD);
    load_check("alias_0", 32'h0, DM_WORD, 32'h55);

    store(32'h8, 32'h0, DM_WORD);
    store(32'hFFFF_0008, 32'hA5, DM_WORD);
`ifdef DM_MMIO_EN
    check("gpio_set", gpio_out, 32'hA5);
    load_check("gpio_rd", 32'hFFFF_0008, DM_BYTE_S, 32'hA5);
    load_check("gpio_no_ram", 32'h8, DM_WORD, 32'h0);
    store(32'hFFFF_0008, 32'h77, DM_BYTE_U);
    check("gpio_sub_word", gpio_out, 32'hA5);
`else
    check("gpio_tied", gpio_out, 32'h0);
    load_check("hi_alias_rd", 32'hFFFF_0008, DM_WORD, 32'hA5);
    load_check("hi_alias_ram", 32'h8, DM_WORD, 32'hA5);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
